axi_fb_rd_dma: RTL

- Parametrised AXI3 read master. Streams a framebuffer out of DDR in fixed-length INCR bursts, wrapping at the end of each frame.
- Buffers pixels in an internal synchronous FIFO and presents them on a valid/ready pixel stream with start-of-frame and end-of-frame flags.
- Single clock domain. Sits between the HP port interconnect and the downstream pixel pipeline, e.g. a clock-crossing FIFO in front of the TMDS encoder.
- Adds over the previous generation:
  - runtime base address and frame size, latched per frame;
  - configurable burst length, data width and pixel width;
  - credit-based FIFO space reservation;
  - enable/stop control;
  - SOF/EOF sideband;
  - error reporting.

---
 rtl/axi_fb_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/axi_fb_rd_dma.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/axi_fb_pkg.sv
// Shared AXI constants, FSM state type and helpers for the framebuffer read DMA.
package axi_fb_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [2:0] PROT_VAL   = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module sync_fifo
    import axi_fb_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic                   wr_en,
    input  logic [W-1:0]           wr_data,
    input  logic                   rd_en,
    output logic [W-1:0]           rd_data,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  count
);

    localparam int PTR_W = clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign empty = (count == '0);
    assign full  = (count == (PTR_W + 1)'(DEPTH));
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            if (do_wr && !do_rd)
                count <= count + 1'b1;
            else if (!do_wr && do_rd)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/axi_fb_rd_dma.sv
// AXI3 read master streaming a framebuffer in fixed INCR bursts into a pixel FIFO
// with SOF/EOF sideband, one burst outstanding at a time.
module axi_fb_rd_dma
    import axi_fb_pkg::*;
#(
    parameter int          AW         = 32,
    parameter int          DW         = 32,
    parameter int          PW         = 24,
    parameter int          BURST_LEN  = 8,
    parameter int          FIFO_DEPTH = 512,
    parameter logic [3:0]  AXI_ID     = 4'd0
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    input  logic          cfg_en,
    input  logic [AW-1:0] cfg_base,
    input  logic [AW-1:0] cfg_frame_bytes,
    output logic [3:0]    ARID,
    output logic [AW-1:0] ARADDR,
    output logic [3:0]    ARLEN,
    output logic [2:0]    ARSIZE,
    output logic [1:0]    ARBURST,
    output logic [1:0]    ARLOCK,
    output logic [3:0]    ARCACHE,
    output logic [2:0]    ARPROT,
    output logic [3:0]    ARQOS,
    output logic          ARVALID,
    input  logic          ARREADY,
    input  logic [3:0]    RID,
    input  logic [DW-1:0] RDATA,
    input  logic [1:0]    RRESP,
    input  logic          RLAST,
    input  logic          RVALID,
    output logic          RREADY,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [PW-1:0] m_data,
    output logic          m_sof,
    output logic          m_eof,
    output logic          busy,
    output logic          frame_done,
    output logic          err_resp,
    output logic          err_proto
);

    localparam int            CW        = clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] BSTEP     = AW'(BURST_LEN * DW / 8);
    localparam logic [4:0]    LAST_BEAT = 5'(BURST_LEN - 1);

    state_t        state, state_n;
    logic [AW-1:0] offset, offset_n;
    logic [AW-1:0] base_q, base_n;
    logic [AW-1:0] fbytes_q, fbytes_n;
    logic [AW-1:0] araddr_n;
    logic          arvalid_n, rready_n, frame_done_n, err_resp_n, err_proto_n;
    logic [4:0]    beat_cnt, beat_n;
    logic [CW:0]   fifo_count;
    logic          fifo_empty;
    logic          beat, credit, last_burst;
    logic [PW+1:0] fifo_wdata, fifo_rdata;

    assign ARID    = AXI_ID;
    assign ARLEN   = 4'(BURST_LEN - 1);
    assign ARSIZE  = 3'(clog2(DW / 8));
    assign ARBURST = BURST_INCR;
    assign ARLOCK  = 2'b00;
    assign ARCACHE = 4'b0000;
    assign ARPROT  = PROT_VAL;
    assign ARQOS   = 4'b0000;
    assign busy    = (state != IDLE);

    // Reserving a whole burst of FIFO space up front means RREADY never has to drop.
    assign credit     = ({1'b0, fifo_count} + (CW + 2)'(BURST_LEN)) <= (CW + 2)'(FIFO_DEPTH);
    assign beat       = RVALID & RREADY;
    assign last_burst = (offset + BSTEP) == fbytes_q;
    assign fifo_wdata = {(offset == '0) && (beat_cnt == 5'd0), last_burst & RLAST, RDATA[PW-1:0]};

    always_comb begin
        state_n      = state;
        araddr_n     = ARADDR;
        arvalid_n    = ARVALID;
        rready_n     = RREADY;
        offset_n     = offset;
        base_n       = base_q;
        fbytes_n     = fbytes_q;
        beat_n       = beat_cnt;
        frame_done_n = 1'b0;
        err_resp_n   = err_resp;
        err_proto_n  = err_proto;
        unique case (state)
            IDLE: begin
                if (cfg_en && credit) begin
                    if (offset == '0) begin
                        base_n   = cfg_base;
                        fbytes_n = cfg_frame_bytes;
                        araddr_n = cfg_base;
                    end else begin
                        araddr_n = base_q + offset;
                    end
                    arvalid_n = 1'b1;
                    state_n   = ADDR;
                end else if (!cfg_en) begin
                    offset_n = '0;
                end
            end
            ADDR: begin
                if (ARREADY) begin
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                    beat_n    = 5'd0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (beat) begin
                    if (beat_cnt != 5'd31) beat_n = beat_cnt + 5'd1;
                    if (RRESP != RESP_OKAY) err_resp_n = 1'b1;
                    if ((RLAST != (beat_cnt == LAST_BEAT)) || (RID != AXI_ID)) err_proto_n = 1'b1;
                    // The burst ends on RLAST wherever it lands; offset still advances a full burst.
                    if (RLAST) begin
                        rready_n = 1'b0;
                        state_n  = IDLE;
                        if (last_burst) begin
                            offset_n     = '0;
                            frame_done_n = 1'b1;
                        end else begin
                            offset_n = offset + BSTEP;
                        end
                        if (!cfg_en) offset_n = '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state      <= IDLE;
            ARADDR     <= '0;
            ARVALID    <= 1'b0;
            RREADY     <= 1'b0;
            offset     <= '0;
            frame_done <= 1'b0;
            err_resp   <= 1'b0;
            err_proto  <= 1'b0;
        end else begin
            state      <= state_n;
            ARADDR     <= araddr_n;
            ARVALID    <= arvalid_n;
            RREADY     <= rready_n;
            offset     <= offset_n;
            frame_done <= frame_done_n;
            err_resp   <= err_resp_n;
            err_proto  <= err_proto_n;
        end
    end

    always_ff @(posedge ACLK) begin
        base_q   <= base_n;
        fbytes_q <= fbytes_n;
        beat_cnt <= beat_n;
    end

    generate
        if (PW < DW) begin : g_rdata_hi
            logic unused_rdata_hi;
            assign unused_rdata_hi = ^RDATA[DW-1:PW];
        end
    endgenerate

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PW + 2)
    ) u_fifo (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .wr_en   (beat),
        .wr_data (fifo_wdata),
        .rd_en   (m_ready),
        .rd_data (fifo_rdata),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign m_valid = ~fifo_empty;
    assign m_data  = fifo_rdata[PW-1:0];
    assign m_eof   = fifo_rdata[PW];
    assign m_sof   = fifo_rdata[PW+1];

endmodule
